// File: rtl/idct_pkg.sv
// idct_pkg: shared constants, FSM state type and rounding helper
// for the serial 8-point row IDCT engine.
package idct_pkg;

   localparam int N     = 8;
   localparam int COS_W = 8;

   typedef enum logic {
      LOAD = 1'b0,
      CALC = 1'b1
   } state_t;

   function automatic int rnd_const(input int frac);
      return (frac > 0) ? (1 << (frac - 1)) : 0;
   endfunction

endpackage

// File: rtl/idct_costable.sv
// idct_costable: combinational cosine table, entry (x,u) =
// round(128 * k(u) * cos((2x+1)u*pi/16)), FRAC = 7.
module idct_costable
   import idct_pkg::*;
(
   input  logic [2:0]              x,
   input  logic [2:0]              u,
   output logic signed [COS_W-1:0] c
);

   always_comb begin
      c = '0;
      unique case ({x, u})
         6'o00: c =  8'sd45;
         6'o01: c =  8'sd63;
         6'o02: c =  8'sd59;
         6'o03: c =  8'sd53;
         6'o04: c =  8'sd45;
         6'o05: c =  8'sd36;
         6'o06: c =  8'sd24;
         6'o07: c =  8'sd12;
         6'o10: c =  8'sd45;
         6'o11: c =  8'sd53;
         6'o12: c =  8'sd24;
         6'o13: c = -8'sd12;
         6'o14: c = -8'sd45;
         6'o15: c = -8'sd63;
         6'o16: c = -8'sd59;
         6'o17: c = -8'sd36;
         6'o20: c =  8'sd45;
         6'o21: c =  8'sd36;
         6'o22: c = -8'sd24;
         6'o23: c = -8'sd63;
         6'o24: c = -8'sd45;
         6'o25: c =  8'sd12;
         6'o26: c =  8'sd59;
         6'o27: c =  8'sd53;
         6'o30: c =  8'sd45;
         6'o31: c =  8'sd12;
         6'o32: c = -8'sd59;
         6'o33: c = -8'sd36;
         6'o34: c =  8'sd45;
         6'o35: c =  8'sd53;
         6'o36: c = -8'sd24;
         6'o37: c = -8'sd63;
         6'o40: c =  8'sd45;
         6'o41: c = -8'sd12;
         6'o42: c = -8'sd59;
         6'o43: c =  8'sd36;
         6'o44: c =  8'sd45;
         6'o45: c = -8'sd53;
         6'o46: c = -8'sd24;
         6'o47: c =  8'sd63;
         6'o50: c =  8'sd45;
         6'o51: c = -8'sd36;
         6'o52: c = -8'sd24;
         6'o53: c =  8'sd63;
         6'o54: c = -8'sd45;
         6'o55: c = -8'sd12;
         6'o56: c =  8'sd59;
         6'o57: c = -8'sd53;
         6'o60: c =  8'sd45;
         6'o61: c = -8'sd53;
         6'o62: c =  8'sd24;
         6'o63: c =  8'sd12;
         6'o64: c = -8'sd45;
         6'o65: c =  8'sd63;
         6'o66: c = -8'sd59;
         6'o67: c =  8'sd36;
         6'o70: c =  8'sd45;
         6'o71: c = -8'sd63;
         6'o72: c =  8'sd59;
         6'o73: c = -8'sd53;
         6'o74: c =  8'sd45;
         6'o75: c = -8'sd36;
         6'o76: c =  8'sd24;
         6'o77: c = -8'sd12;
      endcase
   end

endmodule

// File: rtl/idct8_row.sv
// idct8_row: serial 8-point row IDCT, one shared MAC, 1-deep output.
// Define IDCT_SAT_EN to clamp results instead of wrapping.
module idct8_row
   import idct_pkg::*;
#(
   parameter int IN_W  = 12,
   parameter int OUT_W = 9,
   parameter int FRAC  = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data
);

   localparam int PW = IN_W + COS_W;
   localparam int AW = IN_W + 11;

   localparam logic signed [AW-1:0] RND =
      AW'(rnd_const(FRAC));

   state_t                   state;
   logic [2:0]               u_cnt;
   logic [2:0]               x_cnt;
   logic signed [IN_W-1:0]   coef [N];
   logic signed [AW-1:0]     acc;
   logic signed [COS_W-1:0]  cval;
   logic signed [PW-1:0]     prod;
   logic signed [AW-1:0]     sum;
   logic signed [AW-1:0]     res;
   logic signed [OUT_W-1:0]  smp;
   logic                     stall;

   idct_costable u_tab (
      .x (x_cnt),
      .u (u_cnt),
      .c (cval)
   );

   assign prod = PW'(coef[u_cnt]) * PW'(cval);
   assign sum  = acc + AW'(prod) + RND;
   assign res  = sum >>> FRAC;

`ifdef IDCT_SAT_EN
   localparam logic signed [AW-1:0] MAXV =
      AW'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [AW-1:0] MINV =
      AW'(-(1 << (OUT_W - 1)));

   always_comb begin
      smp = res[OUT_W-1:0];
      if (res > MAXV)
         smp = MAXV[OUT_W-1:0];
      else if (res < MINV)
         smp = MINV[OUT_W-1:0];
   end
`else
   logic unused_hi;

   assign smp       = res[OUT_W-1:0];
   assign unused_hi = ^res[AW-1:OUT_W];
`endif

   // a full output register with no drain freezes the last MAC step
   assign stall = out_valid && !out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= LOAD;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         u_cnt     <= '0;
         x_cnt     <= '0;
         acc       <= '0;
         for (int i = 0; i < N; i++)
            coef[i] <= '0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         unique case (state)
            LOAD: begin
               if (in_valid) begin
                  coef[u_cnt] <= in_data;
                  u_cnt       <= u_cnt + 3'd1;
                  if (u_cnt == 3'd7) begin
                     state    <= CALC;
                     in_ready <= 1'b0;
                     x_cnt    <= '0;
                     acc      <= '0;
                  end
               end
            end
            CALC: begin
               if (u_cnt != 3'd7) begin
                  acc   <= acc + AW'(prod);
                  u_cnt <= u_cnt + 3'd1;
               end else if (!stall) begin
                  out_data  <= smp;
                  out_valid <= 1'b1;
                  acc       <= '0;
                  u_cnt     <= '0;
                  x_cnt     <= x_cnt + 3'd1;
                  if (x_cnt == 3'd7) begin
                     state    <= LOAD;
                     in_ready <= 1'b1;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule
